// File: rtl/multicycle_core.sv
`default_nettype none
// ==== multicycle_core : multicycle MIPS-subset core with one shared valid/ready memory port ====
// ==== Rev 1.0                                                                             ====
module multicycle_core #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    input  logic [4:0]       addressTest,
    output logic [WIDTH-1:0] outputTest,
    output logic             instr_done,
    output logic             trap
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        RTYPE_EX = 4'd6,
        RTYPE_WB = 4'd7,
        ADDI_EX  = 4'd8,
        ADDI_WB  = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] pc;
    logic [31:0]      ir;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] regs [32];

    logic [5:0]       opcode;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [5:0]       funct;
    logic [WIDTH-1:0] sign_imm;
    logic [WIDTH-1:0] jump_target;
    logic             funct_ok;
    logic [WIDTH-1:0] alu_result;

    logic             req_raw;
    logic             we_raw;
    logic [WIDTH-1:0] addr_raw;
    logic [WIDTH-1:0] wdata_raw;
    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [WIDTH-1:0] rf_wdata;

    assign opcode      = ir[31:26];
    assign rs          = ir[25:21];
    assign rt          = ir[20:16];
    assign rd          = ir[15:11];
    assign funct       = ir[5:0];
    assign sign_imm    = {{(WIDTH-16){ir[15]}}, ir[15:0]};
    // pc already points at PC+4 once DECODE is reached
    assign jump_target = {pc[WIDTH-1:28], ir[25:0], 2'b00};
    assign funct_ok    = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                         (funct == FN_OR)  || (funct == FN_SLT);

    always_comb begin
        alu_result = '0;
        case (funct)
            FN_ADD:  alu_result = a + b;
            FN_SUB:  alu_result = a - b;
            FN_AND:  alu_result = a & b;
            FN_OR:   alu_result = a | b;
            FN_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_raw    = 1'b0;
        we_raw     = 1'b0;
        addr_raw   = '0;
        wdata_raw  = '0;
        instr_done = 1'b0;
        trap       = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = rt;
        rf_wdata   = alu_out;
        case (state)
            FETCH: begin
                req_raw  = 1'b1;
                addr_raw = pc;
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = funct_ok ? RTYPE_EX : TRAP;
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_ADDI:      next_state = ADDI_EX;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    default:      next_state = TRAP;
                endcase
            end
            MEMADR:   next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                req_raw  = 1'b1;
                addr_raw = alu_out;
                if (mem_ready) next_state = MEMWB;
            end
            MEMWB: begin
                rf_we      = 1'b1;
                rf_wdata   = data;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                req_raw   = 1'b1;
                we_raw    = 1'b1;
                addr_raw  = alu_out;
                wdata_raw = b;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    next_state = FETCH;
                end
            end
            RTYPE_EX: next_state = RTYPE_WB;
            RTYPE_WB: begin
                rf_we      = 1'b1;
                rf_waddr   = rd;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            ADDI_EX:  next_state = ADDI_WB;
            ADDI_WB: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
                next_state = FETCH;
            end
            BRANCH, JUMP: begin
                instr_done = 1'b1;
                next_state = FETCH;
            end
            TRAP:     trap = 1'b1;
            default:  next_state = FETCH;
        endcase
    end

    // Gating with rst lets an in-flight request drop the moment reset asserts
    assign mem_req   = req_raw & rst;
    assign mem_we    = we_raw & rst;
    assign mem_addr  = rst ? addr_raw : '0;
    assign mem_wdata = rst ? wdata_raw : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc      <= RESET_PC;
            ir      <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
            data    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata[31:0];
                        pc <= pc + PC_STEP;
                    end
                end
                DECODE: begin
                    a       <= regs[rs];
                    b       <= regs[rt];
                    alu_out <= pc + (sign_imm << 2);
                end
                MEMADR, ADDI_EX: alu_out <= a + sign_imm;
                MEMRD:    if (mem_ready) data <= mem_rdata;
                RTYPE_EX: alu_out <= alu_result;
                BRANCH:   if (a == b) pc <= alu_out;
                JUMP:     pc <= jump_target;
                default:  ;
            endcase
        end
    end

    // Register 0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs[rf_waddr] <= rf_wdata;
        end
    end

    assign outputTest = regs[addressTest];

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core.sv
`default_nettype none
// ==== tb_multicycle_core : scoreboard bench for the 32-bit and 64-bit core instances ====
// ==== Rev 1.0                                                                        ====
module tb_multicycle_core;

    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] val;
    } reg_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req, we, ready, done, trap;
    logic [31:0] addr, wdata, rdata, dbg_data;
    logic [4:0]  dbg_addr = 5'd0;

    multicycle_core #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_req(req), .mem_we(we), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata), .mem_ready(ready),
        .addressTest(dbg_addr), .outputTest(dbg_data), .instr_done(done), .trap(trap)
    );

    logic        req64, we64, ready64, done64, trap64;
    logic [63:0] addr64, wdata64, rdata64, dbg_data64;
    logic [4:0]  dbg_addr64 = 5'd0;

    multicycle_core #(.WIDTH(64), .RESET_PC(64'h20)) dut64 (
        .clk(clk), .rst(rst), .mem_req(req64), .mem_we(we64), .mem_addr(addr64),
        .mem_wdata(wdata64), .mem_rdata(rdata64), .mem_ready(ready64),
        .addressTest(dbg_addr64), .outputTest(dbg_data64), .instr_done(done64), .trap(trap64)
    );

    // Word-per-4-bytes memories; the 32-bit one inserts wait_cfg wait cycles per request
    logic [31:0] mem   [256];
    logic [31:0] mem64 [64];
    int          wait_cfg = 0;
    int          wait_cnt = 0;

    assign ready   = req && (wait_cnt >= wait_cfg);
    assign rdata   = mem[addr[9:2]];
    assign ready64 = req64;
    assign rdata64 = {32'hDEAD_BEEF, mem64[addr64[7:2]]};

    always @(posedge clk) begin
        if (req && !ready) wait_cnt <= wait_cnt + 1;
        else               wait_cnt <= 0;
    end

    int       checks = 0;
    int       errors = 0;
    int       exp_done_q [$];
    logic [31:0] exp_fetch_q [$];
    reg_exp_t reg_q [$];

    function automatic logic [31:0] f_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] f_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] f_j(input logic [25:0] target);
        return {6'h02, target};
    endfunction

    task automatic enter_reset();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", req); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", we); end
        checks++; if (addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", addr); end
        checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", wdata); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_instr_done: got %b want 0", done); end
        checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap: got %b want 0", trap); end
        checks++; if (req64 !== 1'b0 || addr64 !== 64'h0) begin
            errors++; $display("FAIL reset_mem64: req %b addr %h want 0/0", req64, addr64);
        end
        for (int r = 0; r < 32; r += 7) begin
            dbg_addr = 5'(r);
            #1;
            checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL reset_reg%0d: got %h want 0", r, dbg_data); end
        end
    endtask

    task automatic test_alu();
        enter_reset();
        wait_cfg = 0;
        mem[0] = f_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = f_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
        mem[2] = f_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[3] = f_r(5'd2, 5'd1, 5'd4, 6'h22);
        mem[4] = f_r(5'd2, 5'd1, 5'd5, 6'h2A);
        mem[5] = f_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        exp_done_q = '{4, 8, 12, 16, 20, 23, 26, 29};
        reg_q.push_back('{5'd1, 64'h5});
        reg_q.push_back('{5'd2, 64'hFFFF_FFFD});
        reg_q.push_back('{5'd3, 64'h2});
        reg_q.push_back('{5'd4, 64'hFFFF_FFF8});
        reg_q.push_back('{5'd5, 64'h1});
        release_reset();
        for (int cyc = 1; cyc <= 30; cyc++) begin
            logic exp_d;
            @(negedge clk);
            if (cyc == 1) begin
                checks++; if (req !== 1'b1 || addr !== 32'h0) begin
                    errors++; $display("FAIL alu_first_fetch: req %b addr %h want 1/0", req, addr);
                end
            end
            exp_d = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
            checks++; if (done !== exp_d) begin
                errors++; $display("FAIL alu_retire cycle %0d: got %b want %b", cyc, done, exp_d);
            end
            if (exp_d) void'(exp_done_q.pop_front());
        end
        checks++; if (exp_done_q.size() != 0) begin errors++; $display("FAIL alu_retire_missing: %0d left want 0", exp_done_q.size()); end
        exp_done_q.delete();
        while (reg_q.size() > 0) begin
            reg_exp_t e = reg_q.pop_front();
            dbg_addr = e.idx;
            #1;
            checks++; if (dbg_data !== e.val[31:0]) begin
                errors++; $display("FAIL alu_reg%0d: got %h want %h", e.idx, dbg_data, e.val[31:0]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic        prev_wait = 1'b0;
        logic [31:0] p_addr = '0, p_wdata = '0;
        logic        p_we = 1'b0;
        enter_reset();
        wait_cfg = 3;
        mem[0]  = f_i(OP_LW, 5'd0, 5'd1, 16'h40);
        mem[1]  = f_j(26'h4);
        mem[4]  = f_i(OP_SW, 5'd0, 5'd1, 16'h8);
        mem[5]  = f_i(OP_LW, 5'd0, 5'd6, 16'h8);
        mem[6]  = f_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        mem[16] = 32'hA5A5_A5A5;
        // lw 11, j 6, sw 10, lw 11, beq 6
        exp_done_q = '{11, 17, 27, 38, 44};
        reg_q.push_back('{5'd1, 64'hA5A5_A5A5});
        reg_q.push_back('{5'd6, 64'hA5A5_A5A5});
        release_reset();
        for (int cyc = 1; cyc <= 45; cyc++) begin
            logic exp_d;
            @(negedge clk);
            exp_d = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
            checks++; if (done !== exp_d) begin
                errors++; $display("FAIL wait_retire cycle %0d: got %b want %b", cyc, done, exp_d);
            end
            if (exp_d) void'(exp_done_q.pop_front());
            if (prev_wait && req) begin
                checks++; if (addr !== p_addr || we !== p_we || wdata !== p_wdata) begin
                    errors++; $display("FAIL wait_stable cycle %0d: addr %h we %b wdata %h want %h %b %h",
                                       cyc, addr, we, wdata, p_addr, p_we, p_wdata);
                end
            end
            if (req && we && ready) begin
                checks++; if (addr !== 32'h8 || wdata !== 32'hA5A5_A5A5) begin
                    errors++; $display("FAIL wait_store: addr %h wdata %h want 8 a5a5a5a5", addr, wdata);
                end
                mem[addr[9:2]] = wdata;
            end
            prev_wait = req && !ready;
            p_addr = addr; p_we = we; p_wdata = wdata;
        end
        checks++; if (exp_done_q.size() != 0) begin errors++; $display("FAIL wait_retire_missing: %0d left want 0", exp_done_q.size()); end
        exp_done_q.delete();
        while (reg_q.size() > 0) begin
            reg_exp_t e = reg_q.pop_front();
            dbg_addr = e.idx;
            #1;
            checks++; if (dbg_data !== e.val[31:0]) begin
                errors++; $display("FAIL wait_reg%0d: got %h want %h", e.idx, dbg_data, e.val[31:0]);
            end
        end
        wait_cfg = 0;
    endtask

    task automatic test_branch_jump();
        for (int run = 0; run < 2; run++) begin
            enter_reset();
            wait_cfg = 0;
            mem[0] = f_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
            mem[1] = f_i(OP_ADDI, 5'd0, 5'd2, 16'd2);
            mem[2] = f_i(OP_ADDI, 5'd0, 5'd0, 16'd7);
            mem[3] = f_i(OP_ADDI, 5'd0, 5'd3, 16'd3);
            mem[4] = (run == 0) ? f_i(OP_BEQ, 5'd1, 5'd2, 16'd2) : f_i(OP_BEQ, 5'd0, 5'd0, 16'd2);
            mem[5] = f_j(26'h40);
            mem[6] = 32'hFC00_0000;
            mem[7] = f_j(26'h40);
            mem[64] = f_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
            exp_fetch_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100, 32'h100};
            if (run == 1) exp_fetch_q[5] = 32'h1C;
            reg_q.push_back('{5'd0, 64'h0});
            reg_q.push_back('{5'd1, 64'h1});
            reg_q.push_back('{5'd2, 64'h2});
            reg_q.push_back('{5'd3, 64'h3});
            release_reset();
            for (int cyc = 1; cyc <= 35; cyc++) begin
                @(negedge clk);
                if (req && !we && ready && exp_fetch_q.size() > 0) begin
                    logic [31:0] e = exp_fetch_q.pop_front();
                    checks++; if (addr !== e) begin
                        errors++; $display("FAIL br_fetch run %0d cycle %0d: got %h want %h", run, cyc, addr, e);
                    end
                end
            end
            checks++; if (exp_fetch_q.size() != 0) begin errors++; $display("FAIL br_fetch_missing run %0d: %0d left want 0", run, exp_fetch_q.size()); end
            exp_fetch_q.delete();
            checks++; if (trap !== 1'b0) begin errors++; $display("FAIL br_trap run %0d: got %b want 0", run, trap); end
            while (reg_q.size() > 0) begin
                reg_exp_t e = reg_q.pop_front();
                dbg_addr = e.idx;
                #1;
                checks++; if (dbg_data !== e.val[31:0]) begin
                    errors++; $display("FAIL br_reg%0d run %0d: got %h want %h", e.idx, run, dbg_data, e.val[31:0]);
                end
            end
        end
    endtask

    task automatic test_trap();
        logic [31:0] bad [2];
        bad[0] = 32'hFC00_0000;
        bad[1] = f_r(5'd1, 5'd2, 5'd3, 6'h21);
        for (int k = 0; k < 2; k++) begin
            enter_reset();
            wait_cfg = 0;
            mem[0] = bad[k];
            release_reset();
            for (int cyc = 1; cyc <= 20; cyc++) begin
                logic exp_t;
                @(negedge clk);
                exp_t = (cyc >= 3);
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL trap_done word %h cycle %0d: got %b want 0", bad[k], cyc, done); end
                checks++; if (trap !== exp_t) begin errors++; $display("FAIL trap_flag word %h cycle %0d: got %b want %b", bad[k], cyc, trap, exp_t); end
                if (exp_t) begin
                    checks++; if (req !== 1'b0) begin errors++; $display("FAIL trap_req cycle %0d: got %b want 0", cyc, req); end
                end
            end
            rst = 1'b0;
            #1;
            checks++; if (trap !== 1'b0) begin errors++; $display("FAIL trap_clear: got %b want 0", trap); end
        end
        mem[0] = f_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = f_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        exp_done_q = '{4, 7};
        release_reset();
        for (int cyc = 1; cyc <= 8; cyc++) begin
            logic exp_d;
            @(negedge clk);
            if (cyc == 1) begin
                checks++; if (req !== 1'b1 || addr !== 32'h0) begin
                    errors++; $display("FAIL trap_refetch: req %b addr %h want 1/0", req, addr);
                end
            end
            exp_d = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
            checks++; if (done !== exp_d) begin errors++; $display("FAIL trap_restart_retire cycle %0d: got %b want %b", cyc, done, exp_d); end
            if (exp_d) void'(exp_done_q.pop_front());
        end
        exp_done_q.delete();
        dbg_addr = 5'd1;
        #1;
        checks++; if (dbg_data !== 32'h5) begin errors++; $display("FAIL trap_restart_reg1: got %h want 5", dbg_data); end
    endtask

    task automatic test_reset_mid();
        enter_reset();
        wait_cfg = 3;
        mem[0] = f_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
        mem[1] = f_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        release_reset();
        // addi retires in cycle 7; the next fetch stalls in cycles 8..10
        repeat (9) @(negedge clk);
        checks++; if (req !== 1'b1 || ready !== 1'b0 || addr !== 32'h4) begin
            errors++; $display("FAIL mid_stall: req %b ready %b addr %h want 1/0/4", req, ready, addr);
        end
        dbg_addr = 5'd1;
        #1;
        checks++; if (dbg_data !== 32'h5) begin errors++; $display("FAIL mid_reg1_before: got %h want 5", dbg_data); end
        rst = 1'b0;
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL mid_req_drop: got %b want 0", req); end
        checks++; if (dbg_data !== 32'h0) begin errors++; $display("FAIL mid_reg1_cleared: got %h want 0", dbg_data); end
        release_reset();
        @(negedge clk);
        checks++; if (req !== 1'b1 || addr !== 32'h0) begin
            errors++; $display("FAIL mid_refetch: req %b addr %h want 1/0", req, addr);
        end
        wait_cfg = 0;
    endtask

    task automatic test_width64();
        enter_reset();
        for (int i = 0; i < 64; i++) mem64[i] = 32'h0;
        mem64[8]  = f_i(OP_ADDI, 5'd0, 5'd1, 16'hFFFF);
        mem64[9]  = f_i(OP_ADDI, 5'd0, 5'd2, 16'd1);
        mem64[10] = f_r(5'd1, 5'd2, 5'd3, 6'h2A);
        mem64[11] = f_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
        exp_done_q = '{4, 8, 12, 15};
        reg_q.push_back('{5'd1, 64'hFFFF_FFFF_FFFF_FFFF});
        reg_q.push_back('{5'd2, 64'h1});
        reg_q.push_back('{5'd3, 64'h1});
        release_reset();
        for (int cyc = 1; cyc <= 16; cyc++) begin
            logic exp_d;
            @(negedge clk);
            if (cyc == 1) begin
                checks++; if (req64 !== 1'b1 || addr64 !== 64'h20) begin
                    errors++; $display("FAIL w64_first_fetch: req %b addr %h want 1/20", req64, addr64);
                end
            end
            exp_d = (exp_done_q.size() > 0) && (exp_done_q[0] == cyc);
            checks++; if (done64 !== exp_d) begin errors++; $display("FAIL w64_retire cycle %0d: got %b want %b", cyc, done64, exp_d); end
            if (exp_d) void'(exp_done_q.pop_front());
        end
        exp_done_q.delete();
        checks++; if (trap64 !== 1'b0 || we64 !== 1'b0 || wdata64 !== 64'h0) begin
            errors++; $display("FAIL w64_idle_outputs: trap %b we %b wdata %h want 0/0/0", trap64, we64, wdata64);
        end
        while (reg_q.size() > 0) begin
            reg_exp_t e = reg_q.pop_front();
            dbg_addr64 = e.idx;
            #1;
            checks++; if (dbg_data64 !== e.val) begin
                errors++; $display("FAIL w64_reg%0d: got %h want %h", e.idx, dbg_data64, e.val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem_wait();
        test_branch_jump();
        test_trap();
        test_reset_mid();
        test_width64();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
